frame_strobe_loader: RTL



---
 rtl/frame_strobe_loader_if.sv | 12 +
 rtl/frame_strobe_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/frame_strobe_loader_if.sv
// Configuration word stream feeding the frame loader: valid/ready handshake
// carrying header and frame words.
interface frame_strobe_loader_if #(
    parameter int FrameBitsPerRow = 32
) ();
    logic [FrameBitsPerRow-1:0] cfg_data;
    logic                       cfg_valid;
    logic                       cfg_ready;

    modport master (output cfg_data, output cfg_valid, input  cfg_ready);
    modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/frame_strobe_loader.sv
// Column-bottom frame loader: decodes a header, then presents each frame word
// on FrameData and pulses a one-hot FrameStrobe with setup/hold margin.
//
// state  | meaning
// IDLE   | waiting for a header word, cfg_ready high
// LOAD   | waiting for the next frame word, cfg_ready high
// SETUP  | FrameData driven, strobe not yet asserted (data setup)
// STROBE | one-hot FrameStrobe asserted for exactly this cycle
// GAP    | strobe low, data held; advance index and remaining count
module frame_strobe_loader #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                       CLK,
    input  logic                       resetn,
    frame_strobe_loader_if.slave       cfg,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err
);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, GAP} state_t;

    localparam logic [6:0]                 MaxFrames = 7'(MaxFramesPerCol);
    localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);

    state_t     state;
    logic [4:0] index;
    logic [5:0] remaining;
    logic       ready_q;

    logic [4:0] hdr_start;
    logic [4:0] hdr_cm1;
    logic [6:0] hdr_end;
    logic       hdr_ok;

    assign hdr_start = cfg.cfg_data[12:8];
    assign hdr_cm1   = cfg.cfg_data[4:0];
    assign hdr_end   = {2'b00, hdr_start} + {2'b00, hdr_cm1} + 7'd1;
    assign hdr_ok    = (cfg.cfg_data[31:24] == 8'hFA) &&
                       ({2'b00, hdr_start} < MaxFrames) &&
                       (hdr_end <= MaxFrames);

    // Ready is purely a registered state decode, never a function of valid.
    assign cfg.cfg_ready = ready_q;

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state       <= IDLE;
            FrameData   <= '0;
            FrameStrobe <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            ready_q     <= 1'b1;
            index       <= '0;
            remaining   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg.cfg_valid) begin
                        if (hdr_ok) begin
                            index     <= hdr_start;
                            remaining <= {1'b0, hdr_cm1} + 6'd1;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (cfg.cfg_valid) begin
                        FrameData <= cfg.cfg_data;
                        ready_q   <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    FrameStrobe <= StrobeOne << index;
                    state       <= STROBE;
                end
                STROBE: begin
                    FrameStrobe <= '0;
                    state       <= GAP;
                end
                GAP: begin
                    index     <= index + 5'd1;
                    remaining <= remaining - 6'd1;
                    ready_q   <= 1'b1;
                    if (remaining == 6'd1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: begin
                    FrameStrobe <= '0;
                    ready_q     <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
